// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants: load strobes, writeback FSM states, widths.
package rv32_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] STRB_B0 = 4'b0001;
  localparam logic [3:0] STRB_B1 = 4'b0010;
  localparam logic [3:0] STRB_B2 = 4'b0100;
  localparam logic [3:0] STRB_B3 = 4'b1000;
  localparam logic [3:0] STRB_H0 = 4'b0011;
  localparam logic [3:0] STRB_H1 = 4'b1100;
  localparam logic [3:0] STRB_W  = 4'b1111;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } wb_state_t;
endpackage

// File: rtl/wb_stage_if.sv
// LSU result bundle plus memory read response feeding the writeback stage.
interface wb_stage_if;
  import rv32_pkg::*;

  logic [XLEN-1:0]   lsu_out;
  logic              lsu_out_vld;
  logic [REG_AW-1:0] lsu_rd;
  logic              lsu_rd_wen;
  logic [3:0]        lsu_rstrb;
  logic              lsu_lsign;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rvld;

  modport master (
    output lsu_out, lsu_out_vld, lsu_rd, lsu_rd_wen,
    output lsu_rstrb, lsu_lsign, mem_rdata, mem_rvld
  );

  modport slave (
    input lsu_out, lsu_out_vld, lsu_rd, lsu_rd_wen,
    input lsu_rstrb, lsu_lsign, mem_rdata, mem_rvld
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data lane select and sign/zero extension (combinational).
module load_align
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [3:0]      rstrb,
  input  logic            lsign,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = rdata;
    unique case (rstrb)
      STRB_B0: data = {{24{lsign & rdata[7]}},  rdata[7:0]};
      STRB_B1: data = {{24{lsign & rdata[15]}}, rdata[15:8]};
      STRB_B2: data = {{24{lsign & rdata[23]}}, rdata[23:16]};
      STRB_B3: data = {{24{lsign & rdata[31]}}, rdata[31:24]};
      STRB_H0: data = {{16{lsign & rdata[15]}}, rdata[15:0]};
      STRB_H1: data = {{16{lsign & rdata[31]}}, rdata[31:16]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU retire, load wait/align, registered RF write port.
// Optional WB_FWD_EN adds a combinational bypass of the next-edge RF write.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  wb_stage_if.slave         lsu,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              wb_load_busy,
  output logic              wb_err_timeout,
  output logic              wb_err_stray
`ifdef WB_FWD_EN
  ,
  output logic              fwd_vld,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(LOAD_TIMEOUT);

  wb_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            is_load;
  logic            retire;
  logic            load_done;
  logic            to_set;
  logic            stray_set;
  logic            wen_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [XLEN-1:0] ld_data;

  assign is_load = lsu.lsu_out_vld & (lsu.lsu_rstrb != 4'b0000);

  load_align u_align (
    .rdata (lsu.mem_rdata),
    .rstrb (lsu.lsu_rstrb),
    .lsign (lsu.lsu_lsign),
    .data  (ld_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retire    = 1'b0;
    load_done = 1'b0;
    to_set    = 1'b0;
    stray_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu.lsu_out_vld && !is_load) begin
          retire = 1'b1;
        end else if (is_load) begin
          if (lsu.mem_rvld) begin
            retire    = 1'b1;
            load_done = 1'b1;
          end else begin
            state_nxt = LOAD_WAIT;
            cnt_nxt   = '0;
          end
        end
        stray_set = lsu.mem_rvld & ~is_load;
      end
      LOAD_WAIT: begin
        if (lsu.mem_rvld) begin
          retire    = 1'b1;
          load_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          // saturate; the flag keeps being re-set, harmless since sticky
          if (cnt != CMAX) cnt_nxt = cnt + CW'(1);
          to_set = (cnt_nxt == CMAX);
        end
      end
      default: state_nxt = IDLE;
    endcase
    wen_nxt   = retire & lsu.lsu_rd_wen & (lsu.lsu_rd != '0);
    wdata_nxt = load_done ? ld_data : lsu.lsu_out;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state          <= IDLE;
      cnt            <= '0;
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      wb_err_timeout <= 1'b0;
      wb_err_stray   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rf_wen <= wen_nxt;
      if (retire) begin
        rf_waddr <= lsu.lsu_rd;
        rf_wdata <= wdata_nxt;
      end
      if (to_set)    wb_err_timeout <= 1'b1;
      if (stray_set) wb_err_stray   <= 1'b1;
    end
  end

  assign wb_load_busy = (state == LOAD_WAIT);

`ifdef WB_FWD_EN
  assign fwd_vld  = wen_nxt;
  assign fwd_rd   = wen_nxt ? lsu.lsu_rd : '0;
  assign fwd_data = wdata_nxt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases then random ALU/load traffic.
module tb_wb_stage;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_load_busy;
  logic        wb_err_timeout;
  logic        wb_err_stray;
`ifdef WB_FWD_EN
  logic        fwd_vld;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage_if bus ();

  wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .lsu            (bus),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .wb_load_busy   (wb_load_busy),
    .wb_err_timeout (wb_err_timeout),
    .wb_err_stray   (wb_err_stray)
`ifdef WB_FWD_EN
    ,
    .fwd_vld        (fwd_vld),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.lsu_out_vld = 1'b0;
    bus.lsu_rstrb   = 4'b0000;
    bus.mem_rvld    = 1'b0;
  endtask

  task automatic present(input logic [31:0] out, input logic [4:0] rd,
                         input logic wen, input logic [3:0] strb,
                         input logic sg);
    bus.lsu_out     = out;
    bus.lsu_out_vld = 1'b1;
    bus.lsu_rd      = rd;
    bus.lsu_rd_wen  = wen;
    bus.lsu_rstrb   = strb;
    bus.lsu_lsign   = sg;
  endtask

  // Reference: pick lane by strobe, then mask and extend arithmetically.
  function automatic logic [31:0] ref_align(logic [31:0] d, logic [3:0] s,
                                            logic sg);
    int          off = 0;
    int          nb  = 4;
    logic [31:0] v, mask;
    if ($countones(s) == 1) begin
      nb  = 1;
      off = $clog2(int'(s));
    end else if (s == 4'b0011) begin
      nb = 2;
    end else if (s == 4'b1100) begin
      nb  = 2;
      off = 2;
    end
    v = d >> (8 * off);
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = v & mask;
      if (sg && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  logic [3:0] strb_tab [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b1100, 4'b1111, 4'b0101,
                               4'b0110};

  initial begin
    bus.lsu_out   = '0;
    bus.lsu_rd    = '0;
    bus.lsu_rd_wen = 1'b0;
    bus.lsu_lsign = 1'b0;
    bus.mem_rdata = '0;
    idle();
    RSTN = 1'b0;
    tick();
    tick();
    check("rst_wen", 32'(rf_wen), 0);
    check("rst_waddr", 32'(rf_waddr), 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy", 32'(wb_load_busy), 0);
    check("rst_to", 32'(wb_err_timeout), 0);
    check("rst_stray", 32'(wb_err_stray), 0);
    RSTN = 1'b1;
    tick();

    // ALU writeback
    present(32'h1234_5678, 5'd5, 1'b1, 4'b0000, 1'b0);
    tick();
    idle();
    check("alu_wen", 32'(rf_wen), 1);
    check("alu_waddr", 32'(rf_waddr), 5);
    check("alu_wdata", rf_wdata, 32'h1234_5678);
    tick();
    check("alu_wen_drop", 32'(rf_wen), 0);

    // rd=0 never writes
    present(32'hDEAD_BEEF, 5'd0, 1'b1, 4'b0000, 1'b0);
    tick();
    idle();
    check("rd0_wen", 32'(rf_wen), 0);

    // LB signed, response three cycles later
    present(32'h0000_1002, 5'd7, 1'b1, 4'b0100, 1'b1);
    bus.mem_rvld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lb_busy", 32'(wb_load_busy), 1);
      check("lb_wen_wait", 32'(rf_wen), 0);
    end
    bus.mem_rvld  = 1'b1;
    bus.mem_rdata = 32'h0080_0000;
    tick();
    idle();
    check("lb_busy_done", 32'(wb_load_busy), 0);
    check("lb_wen", 32'(rf_wen), 1);
    check("lb_waddr", 32'(rf_waddr), 7);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);

    // LHU same-cycle response
    present(32'h0000_2002, 5'd9, 1'b1, 4'b1100, 1'b0);
    bus.mem_rvld  = 1'b1;
    bus.mem_rdata = 32'hBEEF_0000;
    tick();
    idle();
    check("lhu_busy", 32'(wb_load_busy), 0);
    check("lhu_wen", 32'(rf_wen), 1);
    check("lhu_wdata", rf_wdata, 32'h0000_BEEF);

    // random ALU and load traffic against the reference
    for (int t = 0; t < 60; t++) begin
      logic [31:0] out, rdata, exp_d;
      logic [4:0]  rd;
      logic        wen, sg, exp_w, ld;
      logic [3:0]  strb;
      int          lat;
      out   = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      wen   = 1'($urandom_range(0, 3) != 0);
      sg    = 1'($urandom_range(0, 1));
      ld    = 1'($urandom_range(0, 1));
      strb  = ld ? strb_tab[$urandom_range(0, 8)] : 4'b0000;
      lat   = ld ? $urandom_range(0, 3) : 0;
      present(out, rd, wen, strb, sg);
      for (int k = 0; k < lat; k++) begin
        bus.mem_rvld  = 1'b0;
        bus.mem_rdata = $urandom;
        tick();
        check("rnd_busy", 32'(wb_load_busy), 1);
        check("rnd_wen_wait", 32'(rf_wen), 0);
      end
      bus.mem_rvld  = ld;
      bus.mem_rdata = rdata;
      tick();
      idle();
      exp_w = wen && (rd != 0);
      exp_d = ld ? ref_align(rdata, strb, sg) : out;
      check("rnd_busy_done", 32'(wb_load_busy), 0);
      check("rnd_wen", 32'(rf_wen), 32'(exp_w));
      if (exp_w) begin
        check("rnd_waddr", 32'(rf_waddr), 32'(rd));
        check("rnd_wdata", rf_wdata, exp_d);
      end
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check("rnd_idle_wen", 32'(rf_wen), 0);
      end
    end
    check("rnd_to_clear", 32'(wb_err_timeout), 0);
    check("rnd_stray_clear", 32'(wb_err_stray), 0);

    // watchdog timeout with LOAD_TIMEOUT=4
    present(32'h0000_3000, 5'd3, 1'b1, 4'b1111, 1'b0);
    bus.mem_rvld = 1'b0;
    tick();
    tick();
    tick();
    check("to_early", 32'(wb_err_timeout), 0);
    for (int k = 0; k < 4; k++) tick();
    check("to_set", 32'(wb_err_timeout), 1);
    check("to_busy", 32'(wb_load_busy), 1);
    bus.mem_rvld  = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    idle();
    check("to_late_wen", 32'(rf_wen), 1);
    check("to_late_wdata", rf_wdata, 32'hCAFE_F00D);
    check("to_sticky", 32'(wb_err_timeout), 1);

    // stray response in IDLE
    bus.mem_rvld = 1'b1;
    tick();
    idle();
    check("stray_set", 32'(wb_err_stray), 1);
    check("stray_wen", 32'(rf_wen), 0);
    tick();
    check("stray_sticky", 32'(wb_err_stray), 1);

    // reset during LOAD_WAIT abandons the load
    present(32'h0000_4000, 5'd12, 1'b1, 4'b0001, 1'b1);
    tick();
    check("rl_busy", 32'(wb_load_busy), 1);
    RSTN = 1'b0;
    #1;
    check("rl_busy0", 32'(wb_load_busy), 0);
    check("rl_wen0", 32'(rf_wen), 0);
    check("rl_wdata0", rf_wdata, 0);
    check("rl_to0", 32'(wb_err_timeout), 0);
    check("rl_stray0", 32'(wb_err_stray), 0);
    idle();
    tick();
    RSTN = 1'b1;
    tick();
    check("rl_post_wen", 32'(rf_wen), 0);
    tick();
    check("rl_post_wen2", 32'(rf_wen), 0);
    check("rl_post_busy", 32'(wb_load_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
